sc_statemachinelanes: RTL and testbench

SC_STATEMACHINELANES -- requirements
Module: sc_statemachinelanes

---
 rtl/sc_statemachinelanes.sv | 167 ++++++++++++++++
 tb/tb_sc_statemachinelanes.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/sc_statemachinelanes.sv
// Lane sequencer for the frogger-style game: loads, shifts and freezes the car-lane
// shift registers, with shift speed doubling per level.
module sc_statemachinelanes #(
  parameter int TICK_BASE = 5000000,
  parameter int LANES     = 4
) (
  input  logic       SC_STATEMACHINELANES_CLOCK_50,
  input  logic       SC_STATEMACHINELANES_RESET_InLow,
  input  logic       SC_STATEMACHINELANES_startButton_InLow,
  input  logic       SC_STATEMACHINELANES_collision_InLow,
  input  logic       SC_STATEMACHINELANES_levelUp_InLow,
  output logic       SC_STATEMACHINELANES_clear_OutLow,
  output logic       SC_STATEMACHINELANES_load_OutLow,
  output logic [1:0] SC_STATEMACHINELANES_shiftselection_Out,
  output logic [2:0] SC_STATEMACHINELANES_laneSelect_Out,
  output logic [1:0] SC_STATEMACHINELANES_level_Out,
  output logic       SC_STATEMACHINELANES_gameOver_OutHigh
);

  typedef enum logic [2:0] {
    S_RESET0 = 3'd0,
    S_IDLE   = 3'd1,
    S_LOAD   = 3'd2,
    S_WAIT   = 3'd3,
    S_SHIFT  = 3'd4,
    S_FREEZE = 3'd5
  } state_t;

  localparam logic [2:0] LAST_LANE = 3'(LANES - 1);

  // Each level halves the wait; a base that shifts down to zero behaves like a one-cycle wait.
  function automatic logic [25:0] tick_reload(input logic [1:0] lvl);
    logic [25:0] base;
    base = 26'(TICK_BASE >> lvl);
    if (base == 26'd0) begin
      return 26'd0;
    end else begin
      return base - 26'd1;
    end
  endfunction

  state_t      state_q, state_d;
  logic [2:0]  lane_q, lane_d;
  logic [1:0]  level_q, level_d;
  logic [25:0] tick_q, tick_d;
  logic        start_prev_q;
  logic        start_press_s;
  logic        collision_s;
  logic        level_up_s;

  assign start_press_s = start_prev_q & ~SC_STATEMACHINELANES_startButton_InLow;
  assign collision_s   = ~SC_STATEMACHINELANES_collision_InLow;
  assign level_up_s    = ~SC_STATEMACHINELANES_levelUp_InLow;

  // Next-state logic; collision outranks levelUp, which outranks tick expiry.
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    level_d = level_q;
    tick_d  = tick_q;
    case (state_q)
      S_RESET0: begin
        state_d = S_IDLE;
        lane_d  = 3'd0;
      end
      S_IDLE: begin
        if (start_press_s) begin
          state_d = S_LOAD;
          lane_d  = 3'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (lane_q == LAST_LANE) begin
          state_d = S_WAIT;
          lane_d  = 3'd0;
          tick_d  = tick_reload(level_q);
        end else begin
          lane_d  = lane_q + 3'd1;
        end
      end
      S_WAIT: begin
        if (collision_s) begin
          state_d = S_FREEZE;
        end else if (level_up_s) begin
          state_d = S_LOAD;
          lane_d  = 3'd0;
          level_d = (level_q == 2'd3) ? 2'd3 : level_q + 2'd1;
        end else if (tick_q == 26'd0) begin
          state_d = S_SHIFT;
          lane_d  = 3'd0;
        end else begin
          tick_d  = tick_q - 26'd1;
        end
      end
      S_SHIFT: begin
        if (collision_s) begin
          state_d = S_FREEZE;
          lane_d  = 3'd0;
        end else if (lane_q == LAST_LANE) begin
          state_d = S_WAIT;
          lane_d  = 3'd0;
          tick_d  = tick_reload(level_q);
        end else begin
          lane_d  = lane_q + 3'd1;
        end
      end
      S_FREEZE: begin
        if (start_press_s) begin
          state_d = S_RESET0;
          level_d = 2'd0;
          tick_d  = 26'd0;
        end else begin
          state_d = S_FREEZE;
        end
      end
      default: begin
        state_d = S_RESET0;
        lane_d  = 3'd0;
        level_d = 2'd0;
        tick_d  = 26'd0;
      end
    endcase
  end

  // State registers; reset lands in RESET_0 so clear is driven low while held.
  always_ff @(posedge SC_STATEMACHINELANES_CLOCK_50 or negedge SC_STATEMACHINELANES_RESET_InLow) begin
    if (!SC_STATEMACHINELANES_RESET_InLow) begin
      state_q      <= S_RESET0;
      lane_q       <= 3'd0;
      level_q      <= 2'd0;
      tick_q       <= 26'd0;
      start_prev_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      level_q      <= level_d;
      tick_q       <= tick_d;
      start_prev_q <= SC_STATEMACHINELANES_startButton_InLow;
    end
  end

  // Output decode from the registered state; even lanes shift left, odd lanes right.
  always_comb begin
    SC_STATEMACHINELANES_clear_OutLow       = 1'b1;
    SC_STATEMACHINELANES_load_OutLow        = 1'b1;
    SC_STATEMACHINELANES_shiftselection_Out = 2'b11;
    SC_STATEMACHINELANES_laneSelect_Out     = 3'd0;
    SC_STATEMACHINELANES_gameOver_OutHigh   = 1'b0;
    SC_STATEMACHINELANES_level_Out          = level_q;
    case (state_q)
      S_RESET0: SC_STATEMACHINELANES_clear_OutLow = 1'b0;
      S_LOAD: begin
        SC_STATEMACHINELANES_load_OutLow    = 1'b0;
        SC_STATEMACHINELANES_laneSelect_Out = lane_q;
      end
      S_SHIFT: begin
        SC_STATEMACHINELANES_shiftselection_Out = lane_q[0] ? 2'b10 : 2'b01;
        SC_STATEMACHINELANES_laneSelect_Out     = lane_q;
      end
      S_FREEZE: SC_STATEMACHINELANES_gameOver_OutHigh = 1'b1;
      default:  SC_STATEMACHINELANES_clear_OutLow = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_sc_statemachinelanes.sv
// Randomized bench for sc_statemachinelanes against a cycle-level behavioural game model.
module tb_sc_statemachinelanes;

  localparam int TB_TICK  = 8;
  localparam int TB_LANES = 4;
  localparam int N_CYCLES = 4000;

  localparam int M_RST    = 0;
  localparam int M_IDLE   = 1;
  localparam int M_LOAD   = 2;
  localparam int M_WAIT   = 3;
  localparam int M_SHIFT  = 4;
  localparam int M_FROZEN = 5;

  logic       clk;
  logic       rst_n;
  logic       start_n;
  logic       coll_n;
  logic       lvlup_n;
  logic       clear_n;
  logic       load_n;
  logic [1:0] shiftsel;
  logic [2:0] lanesel;
  logic [1:0] level;
  logic       gameover;

  int n_total;
  int n_bad;

  // Behavioural model: mode, current lane, level, cycles already spent waiting, last start sample
  int m_mode;
  int m_lane;
  int m_level;
  int m_elapsed;
  bit m_prev;

  sc_statemachinelanes #(.TICK_BASE(TB_TICK), .LANES(TB_LANES)) dut (
    .SC_STATEMACHINELANES_CLOCK_50(clk),
    .SC_STATEMACHINELANES_RESET_InLow(rst_n),
    .SC_STATEMACHINELANES_startButton_InLow(start_n),
    .SC_STATEMACHINELANES_collision_InLow(coll_n),
    .SC_STATEMACHINELANES_levelUp_InLow(lvlup_n),
    .SC_STATEMACHINELANES_clear_OutLow(clear_n),
    .SC_STATEMACHINELANES_load_OutLow(load_n),
    .SC_STATEMACHINELANES_shiftselection_Out(shiftsel),
    .SC_STATEMACHINELANES_laneSelect_Out(lanesel),
    .SC_STATEMACHINELANES_level_Out(level),
    .SC_STATEMACHINELANES_gameOver_OutHigh(gameover)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t mode=%0d lane=%0d)", tag, got, exp, $time, m_mode, m_lane);
    end
  endtask

  function automatic int wait_len(input int lvl);
    int w;
    w = TB_TICK / (1 << lvl);
    return (w < 1) ? 1 : w;
  endfunction

  task automatic model_reset();
    m_mode = M_RST; m_lane = 0; m_level = 0; m_elapsed = 0; m_prev = 1'b1;
  endtask

  task automatic model_step(input bit s_n, input bit c_n, input bit l_n);
    bit press;
    press  = m_prev && !s_n;
    m_prev = s_n;
    case (m_mode)
      M_RST:  m_mode = M_IDLE;
      M_IDLE: if (press) begin m_mode = M_LOAD; m_lane = 0; end
      M_LOAD: begin
        if (m_lane == TB_LANES - 1) begin m_mode = M_WAIT; m_elapsed = 0; end
        else m_lane++;
      end
      M_WAIT: begin
        if (!c_n) m_mode = M_FROZEN;
        else if (!l_n) begin
          m_level = (m_level >= 3) ? 3 : m_level + 1;
          m_mode = M_LOAD; m_lane = 0;
        end else if (m_elapsed == wait_len(m_level) - 1) begin
          m_mode = M_SHIFT; m_lane = 0;
        end else m_elapsed++;
      end
      M_SHIFT: begin
        if (!c_n) m_mode = M_FROZEN;
        else if (m_lane == TB_LANES - 1) begin m_mode = M_WAIT; m_elapsed = 0; end
        else m_lane++;
      end
      M_FROZEN: if (press) begin m_mode = M_RST; m_level = 0; end
      default: m_mode = M_RST;
    endcase
  endtask

  task automatic check_outputs(input string tag);
    int e_shift;
    int e_lane;
    e_shift = 3;
    e_lane  = 0;
    if (m_mode == M_SHIFT) e_shift = (m_lane % 2 == 0) ? 1 : 2;
    if (m_mode == M_SHIFT || m_mode == M_LOAD) e_lane = m_lane;
    check_eq({tag, ".clear"},    int'(clear_n),  (m_mode == M_RST) ? 0 : 1);
    check_eq({tag, ".load"},     int'(load_n),   (m_mode == M_LOAD) ? 0 : 1);
    check_eq({tag, ".shiftsel"}, int'(shiftsel), e_shift);
    check_eq({tag, ".lanesel"},  int'(lanesel),  e_lane);
    check_eq({tag, ".level"},    int'(level),    m_level);
    check_eq({tag, ".gameover"}, int'(gameover), (m_mode == M_FROZEN) ? 1 : 0);
  endtask

  initial begin
    int  hold_start;
    bit  did_load_rst;
    n_total = 0;
    n_bad = 0;
    hold_start = 0;
    did_load_rst = 1'b0;
    rst_n = 1'b0; start_n = 1'b1; coll_n = 1'b1; lvlup_n = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs("reset");
    rst_n = 1'b1;

    for (int i = 0; i < N_CYCLES; i++) begin
      if (hold_start > 0) begin
        start_n = 1'b0;
        hold_start--;
      end else begin
        start_n = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
      end
      coll_n  = ($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1;
      lvlup_n = ($urandom_range(0, 9) == 0) ? 1'b0 : 1'b1;
      model_step(start_n, coll_n, lvlup_n);
      @(negedge clk);
      check_outputs("run");

      if ((m_mode == M_LOAD && m_lane == 2 && !did_load_rst) || $urandom_range(0, 499) == 0) begin
        if (m_mode == M_LOAD) did_load_rst = 1'b1;
        #2 rst_n = 1'b0;
        start_n = 1'b0;
        model_reset();
        #1 check_outputs("async_rst");
        @(negedge clk);
        check_outputs("rst_hold");
        rst_n = 1'b1;
        hold_start = 3;
      end
    end

    check_eq("mid_load_reset_seen", int'(did_load_rst), 1);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
